// File: rtl/rs485_uart_receiver.sv
// rs485_uart_receiver
//   Serial-to-byte front end for the motor-board RS485 link. The raw line is synchronized,
//   oversampled CLKS_PER_BIT times per bit and each bit is decided by a 3-sample majority vote
//   around mid-bit. A valid frame produces one rx_data_ready pulse with rx_data held until the
//   next valid byte. A bad stop bit (or parity) produces one frame_error pulse and bumps a
//   saturating error counter.
//
//   Optional feature: define RX_PARITY_EN for 8E1 framing (even parity bit after bit 7).
//   Without it the receiver expects 8N1.
//
// Parameters
//   CLKS_PER_BIT   CLK cycles per bit; must be even and >= 8
// Ports
//   CLK            system clock, all logic on posedge
//   reset_n        asynchronous active-low reset
//   rx_i           raw receive line, idle high, asynchronous to CLK
//   rx_data_ready  one-cycle pulse, new valid byte on rx_data
//   rx_data        last valid byte (LSB received first)
//   frame_error    one-cycle pulse, stop bit or parity failed, byte discarded
//   rx_busy        high whenever the receiver is not idle
//   error_count    saturating count of frame_error pulses
module rs485_uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       rx_i,
  output logic       rx_data_ready,
  output logic [7:0] rx_data,
  output logic       frame_error,
  output logic       rx_busy,
  output logic [7:0] error_count
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam logic [CntW-1:0] SampEarly = CntW'(Half - 1);
  localparam logic [CntW-1:0] SampMid   = CntW'(Half);
  localparam logic [CntW-1:0] SampLate  = CntW'(Half + 1);
  localparam logic [CntW-1:0] CntLast   = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q;
  logic            rx_s_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      samp_q, samp_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            ready_q, ready_d;
  logic            ferr_q, ferr_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            vote;
  logic            decide;
  logic            wrap;
  logic            stop_ok;
`ifdef RX_PARITY_EN
  logic            par_err_q, par_err_d;
`endif

  // Two-flop synchronizer; reset to the idle (high) line level.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rx_s_q  <= sync1_q;
    end
  end

  // Majority of the samples at Half-1, Half and the live sample at Half+1.
  assign vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign decide = (cnt_q == SampLate);
  assign wrap   = (cnt_q == CntLast);

`ifdef RX_PARITY_EN
  assign stop_ok = vote & ~par_err_q;
`else
  assign stop_ok = vote;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    samp_d    = samp_q;
    rx_data_d = rx_data_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
    err_cnt_d = err_cnt_q;
`ifdef RX_PARITY_EN
    par_err_d = par_err_q;
`endif

    if (cnt_q == SampEarly) samp_d[0] = rx_s_q;
    if (cnt_q == SampMid)   samp_d[1] = rx_s_q;

    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_idx_d = '0;
`ifdef RX_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (!rx_s_q) state_d = StStart;
      end

      StStart: begin
        if (decide && vote) begin
          // Start bit did not hold low at mid-bit: treat as a glitch.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (wrap) begin
          state_d = StData;
          cnt_d   = '0;
        end
      end

      StData: begin
        if (decide) shift_d = {vote, shift_q[7:1]};
        if (wrap) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef RX_PARITY_EN
      StParity: begin
        // Even parity: data bits XOR parity bit must be zero.
        if (decide) par_err_d = (^shift_q) ^ vote;
        if (wrap) begin
          state_d = StStop;
          cnt_d   = '0;
        end
      end
`endif

      StStop: begin
        // Decide at mid stop bit so an immediately following start edge is not missed.
        if (decide) begin
          cnt_d = '0;
          if (stop_ok) begin
            rx_data_d = shift_q;
            ready_d   = 1'b1;
            state_d   = StIdle;
          end else begin
            ferr_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            // A low stop bit means the line may be held in break; wait for it to recover.
            state_d = vote ? StIdle : StBreak;
          end
        end
      end

      StBreak: begin
        cnt_d = '0;
        if (rx_s_q) state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      samp_q    <= 2'b11;
      rx_data_q <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      rx_data_q <= rx_data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end
`endif

  assign rx_data_ready = ready_q;
  assign rx_data       = rx_data_q;
  assign frame_error   = ferr_q;
  assign rx_busy       = (state_q != StIdle);
  assign error_count   = err_cnt_q;

endmodule

// File: tb/tb_rs485_uart_receiver.sv
// tb_rs485_uart_receiver
//   Directed bench for rs485_uart_receiver at CLKS_PER_BIT=16. Frames are driven one clock at a
//   time from a bit vector; a fractional bit period (hundredths of a cycle) models baud mismatch.
//   A negedge monitor counts pulses and queues received bytes.
module tb_rs485_uart_receiver;

  localparam int Cpb = 16;
`ifdef RX_PARITY_EN
  localparam int Fw = 11;
`else
  localparam int Fw = 10;
`endif
  // rx_i edge to rx_s is 2 cycles; pulse lands 9*Cpb + Cpb/2 + 3 after that (+Cpb with parity).
  localparam int ExpLat = 2 + 9 * Cpb + Cpb / 2 + 3 + (Fw - 10) * Cpb;

  logic       CLK;
  logic       reset_n;
  logic       rx_i;
  logic       rx_data_ready;
  logic [7:0] rx_data;
  logic       frame_error;
  logic       rx_busy;
  logic [7:0] error_count;

  rs485_uart_receiver #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .rx_i         (rx_i),
    .rx_data_ready(rx_data_ready),
    .rx_data      (rx_data),
    .frame_error  (frame_error),
    .rx_busy      (rx_busy),
    .error_count  (error_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int ready_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int last_ready_cyc = 0;
  int last_fe_cyc = 0;
  int start_cyc = 0;
  logic [7:0] rx_q[$];

  always @(negedge CLK) begin
    if (reset_n) begin
      if (rx_data_ready) begin
        ready_cnt++;
        last_ready_cyc = cyc;
        rx_q.push_back(rx_data);
      end
      if (frame_error) begin
        fe_cnt++;
        last_fe_cyc = cyc;
      end
      if (rx_data_ready && frame_error) both_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [31:0] got;
    got = 32'hFFFF_FFFF;
    if (rx_q.size() > 0) got = 32'(rx_q.pop_front());
    check_eq(tag, got, 32'(exp));
  endtask

  // Bit 0 is the start bit; parity (when enabled) is correct even parity.
  function automatic logic [10:0] frame(input logic [7:0] d, input logic stop);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef RX_PARITY_EN
    f[9]   = ^d;
    f[10]  = stop;
`else
    f[9]   = stop;
`endif
    return f;
  endfunction

  // Drives bits[0..nbits-1]; period is the bit time in hundredths of a clock cycle.
  task automatic send_bits(input logic [63:0] bits, input int nbits, input int period);
    int c;
    c = 0;
    start_cyc = cyc;
    while (c * 100 < nbits * period) begin
      rx_i = bits[6'((c * 100) / period)];
      @(posedge CLK);
      #1;
      c++;
    end
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_b2b(input int period);
    logic [63:0] bits;
    logic [7:0]  b [4];
    b = '{8'h1C, 8'hE1, 8'hCE, 8'hBB};
    bits = '1;
    for (int i = 0; i < 4; i++) begin
      bits = bits & ~(64'((1 << Fw) - 1) << (i * Fw));
      bits = bits | (64'(frame(b[i], 1'b1) & 11'((1 << Fw) - 1)) << (i * Fw));
    end
    send_bits(bits, 4 * Fw, period);
    idle(40);
  endtask

  int base_ready;
  int exp_err;
  logic [10:0] f;

  initial begin
    reset_n = 1'b0;
    rx_i    = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("reset_ready", 32'(rx_data_ready), 32'd0);
    check_eq("reset_data", 32'(rx_data), 32'h00);
    check_eq("reset_ferr", 32'(frame_error), 32'd0);
    check_eq("reset_busy", 32'(rx_busy), 32'd0);
    check_eq("reset_errcnt", 32'(error_count), 32'd0);
    reset_n = 1'b1;
    idle(40);
    check_eq("no_pulse_after_reset", 32'(ready_cnt), 32'd0);
    exp_err = 0;

    // 1: single byte 8'hA5
    f = frame(8'hA5, 1'b1);
    send_bits(64'(f), Fw, Cpb * 100);
    idle(40);
    check_eq("a5_count", 32'(ready_cnt), 32'd1);
    check_eq("a5_latency", 32'(last_ready_cyc - start_cyc), 32'(ExpLat));
    expect_byte("a5_byte", 8'hA5);
    check_eq("a5_no_ferr", 32'(fe_cnt), 32'd0);

    // 2: 4-cycle glitch
    rx_i = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check_eq("glitch_busy", 32'(rx_busy), 32'd1);
    idle(60);
    check_eq("glitch_ready", 32'(ready_cnt), 32'd1);
    check_eq("glitch_ferr", 32'(fe_cnt), 32'd0);
    check_eq("glitch_errcnt", 32'(error_count), 32'd0);
    check_eq("glitch_idle", 32'(rx_busy), 32'd0);

    // 3: 8'h00 with low stop bit, line held low 40 bit times, then 8'h3C
    send_bits(64'd0, 40, Cpb * 100);
    check_eq("break_busy", 32'(rx_busy), 32'd1);
    idle(40);
    exp_err++;
    check_eq("break_ferr_once", 32'(fe_cnt), 32'(exp_err));
    check_eq("break_ferr_lat", 32'(last_fe_cyc - start_cyc), 32'(ExpLat));
    check_eq("break_errcnt", 32'(error_count), 32'(exp_err));
    check_eq("break_no_ready", 32'(ready_cnt), 32'd1);
    check_eq("break_data_kept", 32'(rx_data), 32'hA5);
    check_eq("break_recovered", 32'(rx_busy), 32'd0);
    f = frame(8'h3C, 1'b1);
    send_bits(64'(f), Fw, Cpb * 100);
    idle(40);
    check_eq("3c_count", 32'(ready_cnt), 32'd2);
    expect_byte("3c_byte", 8'h3C);

    // 4: back-to-back at +3% and -3% baud
    base_ready = ready_cnt;
    send_b2b(1552);
    check_eq("fast_count", 32'(ready_cnt - base_ready), 32'd4);
    expect_byte("fast_b0", 8'h1C);
    expect_byte("fast_b1", 8'hE1);
    expect_byte("fast_b2", 8'hCE);
    expect_byte("fast_b3", 8'hBB);
    base_ready = ready_cnt;
    send_b2b(1648);
    check_eq("slow_count", 32'(ready_cnt - base_ready), 32'd4);
    expect_byte("slow_b0", 8'h1C);
    expect_byte("slow_b1", 8'hE1);
    expect_byte("slow_b2", 8'hCE);
    expect_byte("slow_b3", 8'hBB);
    check_eq("b2b_no_ferr", 32'(fe_cnt), 32'(exp_err));

`ifdef RX_PARITY_EN
    // 6: parity accepted, then parity wrong with good stop
    base_ready = ready_cnt;
    f = frame(8'h07, 1'b1);
    send_bits(64'(f), Fw, Cpb * 100);
    idle(40);
    check_eq("par_ok_count", 32'(ready_cnt - base_ready), 32'd1);
    expect_byte("par_ok_byte", 8'h07);
    f = frame(8'h07, 1'b1);
    f[9] = 1'b0;
    send_bits(64'(f), Fw, Cpb * 100);
    idle(40);
    exp_err++;
    check_eq("par_bad_ferr", 32'(fe_cnt), 32'(exp_err));
    check_eq("par_bad_errcnt", 32'(error_count), 32'(exp_err));
    check_eq("par_bad_no_ready", 32'(ready_cnt - base_ready), 32'd1);
    check_eq("par_bad_idle", 32'(rx_busy), 32'd0);
`endif

    // 5: reset during data bit 4 of 8'hFF
    base_ready = ready_cnt;
    rx_i = 1'b0;
    repeat (Cpb) @(posedge CLK);
    #1;
    rx_i = 1'b1;
    repeat (4 * Cpb + 8) @(posedge CLK);
    #1;
    check_eq("midbyte_busy", 32'(rx_busy), 32'd1);
    reset_n = 1'b0;
    @(negedge CLK);
    check_eq("rst_busy", 32'(rx_busy), 32'd0);
    check_eq("rst_data", 32'(rx_data), 32'h00);
    check_eq("rst_errcnt", 32'(error_count), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    reset_n = 1'b1;
    idle(300);
    check_eq("post_rst_no_ready", 32'(ready_cnt - base_ready), 32'd0);
    check_eq("post_rst_no_ferr", 32'(fe_cnt), 32'(exp_err));
    check_eq("post_rst_data", 32'(rx_data), 32'h00);
    check_eq("post_rst_errcnt", 32'(error_count), 32'd0);
    check_eq("post_rst_busy", 32'(rx_busy), 32'd0);
    check_eq("no_overlap", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
